// File: rtl/sema_grant_engine.sv
// Round-robin semaphore grant engine: services one packed request per 3-cycle transaction against an ownership table.
// Optional SEMA_ERR_EN enables the illegal-release pulse (sema_err) and the latched offending id (sema_err_id).
module sema_grant_engine #(
    parameter int SEMA_WIDTH     = 8,
    parameter int NUM_THREADS    = 2,
    parameter int NUM_ON_CHIP_IP = 2,
    parameter int NUM_SEMA       = 64
) (
    input  logic                                          clk,
    input  logic                                          reset,
    input  logic [NUM_ON_CHIP_IP*NUM_THREADS*SEMA_WIDTH-1:0] semareq_bus,
    output logic [NUM_ON_CHIP_IP*NUM_THREADS-1:0]         semaack,
    output logic [NUM_ON_CHIP_IP*NUM_THREADS-1:0]         semagrant,
    output logic [$clog2(NUM_SEMA+1)-1:0]                 sema_held_cnt,
    output logic                                          sema_err,
    output logic [SEMA_WIDTH-3:0]                         sema_err_id
);

    localparam int unsigned NS = NUM_ON_CHIP_IP * NUM_THREADS;
    localparam int unsigned PW = (NS > 1) ? $clog2(NS) : 1;
    localparam int unsigned IW = SEMA_WIDTH - 2;

    typedef enum logic [1:0] {IDLE, EXEC, ACK} state_t;

    state_t                  state, state_nxt;
    logic [SEMA_WIDTH-1:0]   word [NS];
    logic [NS-1:0]           valid_vec, elig, prev_ack, req_onehot;
    logic                    found;
    logic [PW-1:0]           win, cand, rr_ptr, req_slot;
    int unsigned             sum;
    logic                    req_op;
    logic [IW-1:0]           req_id;
    logic [NUM_SEMA-1:0]     owned;
    logic [PW-1:0]           owner [NUM_SEMA];
    logic                    cur_mine;
    logic                    exec_grant, exec_set, exec_clr, exec_err;

    for (genvar g = 0; g < NS; g++) begin : g_slot
        assign word[g]      = semareq_bus[g*SEMA_WIDTH +: SEMA_WIDTH];
        assign valid_vec[g] = word[g][SEMA_WIDTH-1];
    end

    // The slot acked last cycle may still show its old word; keep it out of this arbitration.
    assign elig       = valid_vec & ~prev_ack;
    assign req_onehot = NS'(1) << req_slot;
    assign cur_mine   = owned[req_id] && (owner[req_id] == req_slot);

    always_comb begin
        found = 1'b0;
        win   = '0;
        sum   = 0;
        cand  = '0;
        for (int unsigned k = 0; k < NS; k++) begin
            sum = 32'(rr_ptr) + k;
            if (sum >= NS) begin
                sum = sum - NS;
            end
            cand = PW'(sum);
            if (!found && elig[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = found ? EXEC : IDLE;
            EXEC:    state_nxt = ACK;
            ACK:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        exec_grant = 1'b0;
        exec_set   = 1'b0;
        exec_clr   = 1'b0;
        exec_err   = 1'b0;
        if (state == EXEC) begin
            if (!req_op) begin
                exec_grant = !owned[req_id] || cur_mine;
                exec_set   = !owned[req_id];
            end else begin
                exec_grant = cur_mine;
                exec_clr   = cur_mine;
                exec_err   = !cur_mine;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_ptr        <= '0;
            req_slot      <= '0;
            req_op        <= 1'b0;
            req_id        <= '0;
            prev_ack      <= '0;
            semaack       <= '0;
            semagrant     <= '0;
            sema_held_cnt <= '0;
            owned         <= '0;
        end else begin
            prev_ack  <= semaack;
            semaack   <= (state == EXEC) ? req_onehot : '0;
            semagrant <= exec_grant ? req_onehot : '0;
            if (state == IDLE && found) begin
                req_slot <= win;
                req_op   <= word[win][SEMA_WIDTH-2];
                req_id   <= word[win][IW-1:0];
                rr_ptr   <= (32'(win) == NS - 1) ? '0 : win + 1'b1;
            end
            if (exec_set) begin
                owned[req_id] <= 1'b1;
                sema_held_cnt <= sema_held_cnt + 1'b1;
            end else if (exec_clr) begin
                owned[req_id] <= 1'b0;
                sema_held_cnt <= sema_held_cnt - 1'b1;
            end
        end
    end

    // Owner field is only meaningful while its owned bit is set, so it needs no reset.
    always_ff @(posedge clk) begin
        if (exec_set) begin
            owner[req_id] <= req_slot;
        end
    end

`ifdef SEMA_ERR_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sema_err    <= 1'b0;
            sema_err_id <= '0;
        end else begin
            sema_err <= exec_err;
            if (exec_err) begin
                sema_err_id <= req_id;
            end
        end
    end
`else
    logic unused_err;
    assign unused_err  = exec_err;
    assign sema_err    = 1'b0;
    assign sema_err_id = '0;
`endif

endmodule
